sub_bytes_sched: RTL and testbench

Sequenced, shared SubBytes engine for the AES datapath. It holds one 32-bit S-box lane (four `Sbox` instances) and shares it between two requesters: the round datapath's 128-bit state SubBytes, processed one word per cycle over four cycles, and the key schedule's 32-bit SubWord. It replaces a full 16-instance SubBytes array wherever area matters more than latency. It sits between the round controller and key-expansion logic on one side and the existing `Sbox` module on the other.

---
 rtl/aes_pkg.sv | 17 +
 rtl/sub_bytes_sched_if.sv | 32 +++
 rtl/sbox.sv | 32 +++
 rtl/sub_word.sv | 16 +
 rtl/sub_bytes_sched.sv | 113 +++++++++++
 tb/tb_sub_bytes_sched.sv | 325 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types for the sequenced SubBytes engine.
package aes_pkg;

  localparam int unsigned BYTE     = 8;
  localparam int unsigned DWORD    = 32;
  localparam int unsigned LENGTH   = 128;
  localparam int unsigned WORD_LSB = $clog2(DWORD);

  typedef enum logic [1:0] {
    IDLE,
    ST_RUN,
    KEY_RUN
  } state_t;

  typedef logic [1:0] widx_t;

endpackage

// File: rtl/sub_bytes_sched_if.sv
// Request/response handshakes for the shared SubBytes lane (state and key-schedule sides).
interface sub_bytes_sched_if;
  import aes_pkg::*;

  logic [LENGTH-1:0] st_in;
  logic              st_in_valid;
  logic              st_in_ready;
  logic [LENGTH-1:0] st_out;
  logic              st_out_valid;
  logic              st_out_ready;
  logic [DWORD-1:0]  key_in;
  logic              key_in_valid;
  logic              key_in_ready;
  logic [DWORD-1:0]  key_out;
  logic              key_out_valid;
  logic              key_out_ready;

  modport master (
    output st_in, st_in_valid, st_out_ready,
    output key_in, key_in_valid, key_out_ready,
    input  st_in_ready, st_out, st_out_valid,
    input  key_in_ready, key_out, key_out_valid
  );

  modport slave (
    input  st_in, st_in_valid, st_out_ready,
    input  key_in, key_in_valid, key_out_ready,
    output st_in_ready, st_out, st_out_valid,
    output key_in_ready, key_out, key_out_valid
  );

endinterface

// File: rtl/sbox.sv
// AES forward S-box as a constant lookup; byte i of the table sits at the MSB end.
module Sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  // Entry i lives at bit offset (255-i)*8, and 255-i is simply ~i.
  assign base = {~a, 3'b000};
  assign s    = TABLE[base +: 8];

endmodule

// File: rtl/sub_word.sv
// One 32-bit S-box lane: byte k of the word maps to byte k of the result.
module sub_word
  import aes_pkg::*;
(
  input  logic [DWORD-1:0] word,
  output logic [DWORD-1:0] sub
);

  for (genvar k = 0; k < DWORD / BYTE; k++) begin : g_lane
    Sbox u_sbox (
      .a (word[k*BYTE +: BYTE]),
      .s (sub[k*BYTE +: BYTE])
    );
  end

endmodule

// File: rtl/sub_bytes_sched.sv
// Shares one SubWord lane between 4-cycle state SubBytes and 1-cycle key SubWord,
// round-robin arbitrated, each result held in its own output slot.
module sub_bytes_sched
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sub_bytes_sched_if.slave  bus,
  output logic              busy
);

  state_t            state, state_nxt;
  widx_t             widx;
  logic              last_grant;
  logic [LENGTH-1:0] st_buf;
  logic [DWORD-1:0]  key_buf;
  logic [LENGTH-1:0] st_out_q;
  logic              st_out_valid_q;
  logic [DWORD-1:0]  key_out_q;
  logic              key_out_valid_q;
  logic              st_ready, key_ready;
  logic              st_grant, key_grant;
  logic [DWORD-1:0]  lane_in, lane_out;

  // Readiness decodes only from registered state, never from valid/ready inputs.
  assign st_ready  = (state == IDLE) && !st_out_valid_q && !rst;
  assign key_ready = (state == IDLE) && !key_out_valid_q && !rst;
  assign busy      = (state != IDLE);

  assign bus.st_in_ready   = st_ready;
  assign bus.key_in_ready  = key_ready;
  assign bus.st_out        = st_out_q;
  assign bus.st_out_valid  = st_out_valid_q;
  assign bus.key_out       = key_out_q;
  assign bus.key_out_valid = key_out_valid_q;

  sub_word u_lane (
    .word (lane_in),
    .sub  (lane_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant, lane mux and next state.
  always_comb begin
    state_nxt = state;
    st_grant  = 1'b0;
    key_grant = 1'b0;
    lane_in   = '0;
    case (state)
      IDLE: begin
        if (bus.st_in_valid && st_ready && bus.key_in_valid && key_ready) begin
          if (last_grant) st_grant  = 1'b1;
          else            key_grant = 1'b1;
        end else if (bus.st_in_valid && st_ready) begin
          st_grant = 1'b1;
        end else if (bus.key_in_valid && key_ready) begin
          key_grant = 1'b1;
        end
        if (st_grant)       state_nxt = ST_RUN;
        else if (key_grant) state_nxt = KEY_RUN;
      end
      ST_RUN: begin
        lane_in = st_buf[{widx, WORD_LSB'(0)} +: DWORD];
        if (widx == 2'd3) state_nxt = IDLE;
      end
      KEY_RUN: begin
        lane_in   = key_buf;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request buffers, word index and output slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx            <= '0;
      last_grant      <= 1'b1;
      st_buf          <= '0;
      key_buf         <= '0;
      st_out_q        <= '0;
      st_out_valid_q  <= 1'b0;
      key_out_q       <= '0;
      key_out_valid_q <= 1'b0;
    end else begin
      if (st_out_valid_q && bus.st_out_ready)   st_out_valid_q  <= 1'b0;
      if (key_out_valid_q && bus.key_out_ready) key_out_valid_q <= 1'b0;
      if (st_grant) begin
        st_buf     <= bus.st_in;
        widx       <= '0;
        last_grant <= 1'b0;
      end
      if (key_grant) begin
        key_buf    <= bus.key_in;
        last_grant <= 1'b1;
      end
      if (state == ST_RUN) begin
        st_out_q[{widx, WORD_LSB'(0)} +: DWORD] <= lane_out;
        widx <= widx_t'(widx + 2'd1);
        if (widx == 2'd3) st_out_valid_q <= 1'b1;
      end
      if (state == KEY_RUN) begin
        key_out_q       <= lane_out;
        key_out_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_sched.sv
// Scoreboard bench for sub_bytes_sched: expected results come from a GF(2^8) S-box model.
module tb_sub_bytes_sched;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  sub_bytes_sched_if bus ();

  sub_bytes_sched dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_check = 0;
  int n_pass  = 0;
  logic [LENGTH-1:0] st_q[$];
  logic [DWORD-1:0]  key_q[$];
  logic [LENGTH-1:0] st_exp;
  logic [DWORD-1:0]  key_exp;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [DWORD-1:0] word_ref(input logic [DWORD-1:0] w);
    logic [DWORD-1:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = sbox_ref(w[k*8 +: 8]);
    return r;
  endfunction

  function automatic logic [LENGTH-1:0] state_ref(input logic [LENGTH-1:0] s);
    logic [LENGTH-1:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = word_ref(s[k*32 +: 32]);
    return r;
  endfunction

  // Scoreboard: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && bus.st_out_valid && bus.st_out_ready) begin
      n_check++;
      if (st_q.size() == 0) $display("FAIL st_sb: unexpected st_out %h", bus.st_out);
      else begin
        st_exp = st_q.pop_front();
        if (bus.st_out !== st_exp) $display("FAIL st_sb: got %h want %h", bus.st_out, st_exp);
        else n_pass++;
      end
    end
    if (!rst && bus.key_out_valid && bus.key_out_ready) begin
      n_check++;
      if (key_q.size() == 0) $display("FAIL key_sb: unexpected key_out %h", bus.key_out);
      else begin
        key_exp = key_q.pop_front();
        if (bus.key_out !== key_exp) $display("FAIL key_sb: got %h want %h", bus.key_out, key_exp);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    st_q.delete();
    key_q.delete();
    rst = 1'b0;
    #1;
  endtask

  task automatic send_st(input logic [LENGTH-1:0] s);
    bit ok = 1'b0;
    bus.st_in = s;
    bus.st_in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.st_in_ready) begin ok = 1'b1; break; end
      tick();
    end
    n_check++;
    if (!ok) $display("FAIL st_accept: st_in_ready=0 want 1 within 40 cycles");
    else begin n_pass++; st_q.push_back(state_ref(s)); end
    tick();
    bus.st_in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [DWORD-1:0] k);
    bit ok = 1'b0;
    bus.key_in = k;
    bus.key_in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.key_in_ready) begin ok = 1'b1; break; end
      tick();
    end
    n_check++;
    if (!ok) $display("FAIL key_accept: key_in_ready=0 want 1 within 40 cycles");
    else begin n_pass++; key_q.push_back(word_ref(k)); end
    tick();
    bus.key_in_valid = 1'b0;
  endtask

  task automatic wait_st_out();
    for (int i = 0; i < 12 && !bus.st_out_valid; i++) tick();
    n_check++;
    if (bus.st_out_valid !== 1'b1) $display("FAIL st_wait: st_out_valid=%b want 1", bus.st_out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_check++; if ({bus.st_in_ready, bus.key_in_ready, busy} !== 3'b000) $display("FAIL rst_ready: got %b want 000", {bus.st_in_ready, bus.key_in_ready, busy}); else n_pass++;
    rst = 1'b0;
    #1;
    n_check++; if ({bus.st_in_ready, bus.key_in_ready, busy, bus.st_out_valid, bus.key_out_valid} !== 5'b11000) $display("FAIL rst_state: got %b want 11000", {bus.st_in_ready, bus.key_in_ready, busy, bus.st_out_valid, bus.key_out_valid}); else n_pass++;
    n_check++; if ({bus.st_out, bus.key_out} !== '0) $display("FAIL rst_data: got %h/%h want 0", bus.st_out, bus.key_out); else n_pass++;
  endtask

  task automatic test_key_basic();
    bus.key_out_ready = 1'b1;
    send_key(32'h0000_0000);
    n_check++; if ({busy, bus.key_out_valid} !== 2'b10) $display("FAIL key_t1: busy,valid=%b want 10", {busy, bus.key_out_valid}); else n_pass++;
    tick();
    n_check++; if (bus.key_out_valid !== 1'b1) $display("FAIL key_t2: key_out_valid=%b want 1", bus.key_out_valid); else n_pass++;
    n_check++; if (bus.key_out !== 32'h6363_6363) $display("FAIL key_val: got %h want 63636363", bus.key_out); else n_pass++;
    tick();
    n_check++; if (bus.key_out_valid !== 1'b0) $display("FAIL key_t3: key_out_valid=%b want 0", bus.key_out_valid); else n_pass++;
  endtask

  task automatic test_state_basic();
    int busy_cnt = 0;
    bus.st_out_ready = 1'b1;
    send_st({16{8'h53}});
    for (int j = 1; j <= 6; j++) begin
      if (busy) busy_cnt++;
      if (j == 4) begin n_check++; if (bus.st_out_valid !== 1'b0) $display("FAIL st_t4: st_out_valid=%b want 0", bus.st_out_valid); else n_pass++; end
      if (j == 5) begin
        n_check++; if (bus.st_out_valid !== 1'b1) $display("FAIL st_t5: st_out_valid=%b want 1", bus.st_out_valid); else n_pass++;
        n_check++; if (bus.st_out !== {16{8'hED}}) $display("FAIL st_val: got %h want all ED", bus.st_out); else n_pass++;
      end
      if (j == 6) begin n_check++; if (bus.st_out_valid !== 1'b0) $display("FAIL st_t6: st_out_valid=%b want 0", bus.st_out_valid); else n_pass++; end
      if (j < 6) tick();
    end
    n_check++; if (busy_cnt != 4) $display("FAIL st_busy: busy cycles=%0d want 4", busy_cnt); else n_pass++;
  endtask

  task automatic test_ordering();
    bus.st_out_ready = 1'b1;
    send_st({4{32'hFF01_0053}});
    wait_st_out();
    n_check++; if (bus.st_out !== {4{32'h167C_63ED}}) $display("FAIL byte_order: got %h want 4x167c63ed", bus.st_out); else n_pass++;
    tick();
    send_st({32'hFFFF_FFFF, 32'h0101_0101, 32'h5353_5353, 32'h0000_0000});
    wait_st_out();
    n_check++; if (bus.st_out !== {32'h1616_1616, 32'h7C7C_7C7C, 32'hEDED_EDED, 32'h6363_6363}) $display("FAIL word_order: got %h", bus.st_out); else n_pass++;
    tick();
  endtask

  task automatic test_tie();
    logic [LENGTH-1:0] s1, s2;
    logic [DWORD-1:0] k1;
    s1 = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    k1 = $urandom;
    do_reset();
    bus.st_out_ready = 1'b1;
    bus.key_out_ready = 1'b1;
    bus.st_in = s1; bus.st_in_valid = 1'b1;
    bus.key_in = k1; bus.key_in_valid = 1'b1;
    n_check++; if ({bus.st_in_ready, bus.key_in_ready} !== 2'b11) $display("FAIL tie1_ready: got %b want 11", {bus.st_in_ready, bus.key_in_ready}); else n_pass++;
    st_q.push_back(state_ref(s1));
    tick();
    bus.st_in_valid = 1'b0; bus.key_in_valid = 1'b0;
    n_check++; if (busy !== 1'b1) $display("FAIL tie1_busy: busy=%b want 1", busy); else n_pass++;
    tick();
    n_check++; if (bus.key_out_valid !== 1'b0) $display("FAIL tie1_winner: key_out_valid=%b want 0", bus.key_out_valid); else n_pass++;
    tick(); tick(); tick();
    n_check++; if (bus.st_out_valid !== 1'b1) $display("FAIL tie1_st: st_out_valid=%b want 1", bus.st_out_valid); else n_pass++;
    tick();
    bus.st_in = s2; bus.st_in_valid = 1'b1;
    bus.key_in_valid = 1'b1;
    n_check++; if ({bus.st_in_ready, bus.key_in_ready} !== 2'b11) $display("FAIL tie2_ready: got %b want 11", {bus.st_in_ready, bus.key_in_ready}); else n_pass++;
    key_q.push_back(word_ref(k1));
    tick();
    bus.key_in_valid = 1'b0;
    tick();
    n_check++; if ({bus.key_out_valid, bus.st_out_valid} !== 2'b10) $display("FAIL tie2_winner: key,st valid=%b want 10", {bus.key_out_valid, bus.st_out_valid}); else n_pass++;
    n_check++; if (bus.st_in_ready !== 1'b1) $display("FAIL tie2_st_ready: st_in_ready=%b want 1", bus.st_in_ready); else n_pass++;
    st_q.push_back(state_ref(s2));
    tick();
    bus.st_in_valid = 1'b0;
    wait_st_out();
    tick();
  endtask

  task automatic test_block();
    logic [LENGTH-1:0] s, s2;
    s  = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    bus.st_out_ready = 1'b0;
    bus.key_out_ready = 1'b1;
    send_st(s);
    tick(); tick(); tick(); tick();
    n_check++; if ({bus.st_out_valid, bus.st_in_ready} !== 2'b10) $display("FAIL blk_hold: valid,ready=%b want 10", {bus.st_out_valid, bus.st_in_ready}); else n_pass++;
    bus.st_in = s2; bus.st_in_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      send_key($urandom);
      tick();
      n_check++; if ({bus.key_out_valid, bus.st_in_ready} !== 2'b10) $display("FAIL blk_key%0d: key_valid,st_ready=%b want 10", n, {bus.key_out_valid, bus.st_in_ready}); else n_pass++;
      tick();
    end
    n_check++; if (bus.st_out_valid !== 1'b1 || bus.st_out !== state_ref(s)) $display("FAIL blk_stable: valid=%b data=%h want 1/%h", bus.st_out_valid, bus.st_out, state_ref(s)); else n_pass++;
    bus.st_out_ready = 1'b1;
    n_check++; if (bus.st_in_ready !== 1'b0) $display("FAIL blk_passthru: st_in_ready=%b want 0", bus.st_in_ready); else n_pass++;
    tick();
    n_check++; if (bus.st_in_ready !== 1'b1) $display("FAIL blk_reopen: st_in_ready=%b want 1", bus.st_in_ready); else n_pass++;
    st_q.push_back(state_ref(s2));
    tick();
    bus.st_in_valid = 1'b0;
    wait_st_out();
    tick();
  endtask

  task automatic test_back_to_back();
    int  st_sent = 0, key_sent = 0;
    bit  st_acc, key_acc, lg;
    do_reset();
    lg = 1'b1;
    for (int c = 0; c < 3000 && (st_sent < 6 || key_sent < 10); c++) begin
      if (!bus.st_in_valid && st_sent < 6 && $urandom_range(1, 0) == 1) begin
        bus.st_in = {$urandom, $urandom, $urandom, $urandom};
        bus.st_in_valid = 1'b1;
      end
      if (!bus.key_in_valid && key_sent < 10 && $urandom_range(1, 0) == 1) begin
        bus.key_in = $urandom;
        bus.key_in_valid = 1'b1;
      end
      bus.st_out_ready  = ($urandom_range(3, 0) != 0);
      bus.key_out_ready = ($urandom_range(3, 0) != 0);
      st_acc  = bus.st_in_valid && bus.st_in_ready;
      key_acc = bus.key_in_valid && bus.key_in_ready;
      if (st_acc && key_acc) begin
        if (lg) key_acc = 1'b0;
        else    st_acc  = 1'b0;
      end
      if (st_acc)  begin st_q.push_back(state_ref(bus.st_in)); st_sent++;  lg = 1'b0; end
      if (key_acc) begin key_q.push_back(word_ref(bus.key_in)); key_sent++; lg = 1'b1; end
      tick();
      if (st_acc)  bus.st_in_valid  = 1'b0;
      if (key_acc) bus.key_in_valid = 1'b0;
    end
    n_check++; if (st_sent != 6 || key_sent != 10) $display("FAIL b2b_sent: st=%0d key=%0d want 6/10", st_sent, key_sent); else n_pass++;
    bus.st_out_ready = 1'b1;
    bus.key_out_ready = 1'b1;
    for (int i = 0; i < 30 && (st_q.size() != 0 || key_q.size() != 0); i++) tick();
    n_check++; if (st_q.size() != 0 || key_q.size() != 0) $display("FAIL b2b_drain: pending st=%0d key=%0d want 0/0", st_q.size(), key_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    bus.st_out_ready = 1'b1;
    bus.key_out_ready = 1'b1;
    send_st({$urandom, $urandom, $urandom, $urandom});
    tick(); tick();
    rst = 1'b1;
    n_check++; if ({bus.st_in_ready, bus.key_in_ready} !== 2'b00) $display("FAIL mid_rst_ready: got %b want 00", {bus.st_in_ready, bus.key_in_ready}); else n_pass++;
    tick();
    n_check++; if ({busy, bus.st_out_valid, bus.key_out_valid} !== 3'b000) $display("FAIL mid_rst_state: busy,st_v,key_v=%b want 000", {busy, bus.st_out_valid, bus.key_out_valid}); else n_pass++;
    n_check++; if (bus.st_out !== '0) $display("FAIL mid_rst_data: st_out=%h want 0", bus.st_out); else n_pass++;
    st_q.delete();
    key_q.delete();
    rst = 1'b0;
    #1;
    n_check++; if ({bus.st_in_ready, bus.key_in_ready} !== 2'b11) $display("FAIL mid_idle: readys=%b want 11", {bus.st_in_ready, bus.key_in_ready}); else n_pass++;
    send_key($urandom);
    tick();
    n_check++; if (bus.key_out_valid !== 1'b1) $display("FAIL mid_key: key_out_valid=%b want 1", bus.key_out_valid); else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.st_in = '0;  bus.st_in_valid = 1'b0;  bus.st_out_ready = 1'b0;
    bus.key_in = '0; bus.key_in_valid = 1'b0; bus.key_out_ready = 1'b0;
    test_reset();
    test_key_basic();
    test_state_basic();
    test_ordering();
    test_tie();
    test_block();
    test_back_to_back();
    test_reset_midrun();
    n_check++;
    if (st_q.size() != 0 || key_q.size() != 0) $display("FAIL final_drain: pending st=%0d key=%0d want 0/0", st_q.size(), key_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
